// File: rtl/netwalk_encoder.sv
// Round-robin multi-hot to binary encoder: walks every set bit of an accepted request
// vector and emits its indices one per output handshake, resuming from the last position.
module netwalk_encoder #(
  parameter int ENCODER_OUT_WIDTH = 4,
  parameter int ENCODER_IN_WIDTH  = 1 << ENCODER_OUT_WIDTH
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [ENCODER_IN_WIDTH-1:0]  encoder_in,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [ENCODER_OUT_WIDTH-1:0] encoder_out,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         encoder_last,
  output logic                         encoder_zero,
  output logic                         dbg_busy,
  output logic [ENCODER_OUT_WIDTH-1:0] dbg_ptr
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1.
  // in_ready comes only from the state register; the output register may be reloaded
  // whenever it is empty or its current value is being consumed (out_ready=1).

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam logic [ENCODER_OUT_WIDTH:0]   IN_W_EXT = (ENCODER_OUT_WIDTH+1)'(ENCODER_IN_WIDTH);
  localparam logic [ENCODER_OUT_WIDTH-1:0] LAST_IDX = ENCODER_OUT_WIDTH'(ENCODER_IN_WIDTH - 1);
  localparam logic [ENCODER_IN_WIDTH-1:0]  ONE_HOT0 = ENCODER_IN_WIDTH'(1);

  state_t                         state_q, state_d;
  logic [ENCODER_IN_WIDTH-1:0]    pending_q, pending_d;
  logic [ENCODER_OUT_WIDTH-1:0]   ptr_q, ptr_d;
  logic [ENCODER_OUT_WIDTH-1:0]   out_q, out_d;
  logic                           out_valid_q, out_valid_d;
  logic                           last_q, last_d;
  logic                           zero_q, zero_d;

  logic                           slot_free;
  logic                           found;
  logic [ENCODER_OUT_WIDTH-1:0]   pick;
  logic [ENCODER_OUT_WIDTH:0]     idx_w;
  logic [ENCODER_IN_WIDTH-1:0]    remaining;

  assign slot_free = !out_valid_q || out_ready;

  // First set pending bit at or above ptr, wrapping around the vector.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx_w = '0;
    for (int i = 0; i < ENCODER_IN_WIDTH; i++) begin
      idx_w = {1'b0, ptr_q} + (ENCODER_OUT_WIDTH+1)'(i);
      if (idx_w >= IN_W_EXT) begin
        idx_w = idx_w - IN_W_EXT;
      end
      if (!found && pending_q[idx_w[ENCODER_OUT_WIDTH-1:0]]) begin
        found = 1'b1;
        pick  = idx_w[ENCODER_OUT_WIDTH-1:0];
      end
    end
  end

  assign remaining = pending_q & ~(ONE_HOT0 << pick);

  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    ptr_d       = ptr_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    last_d      = last_q;
    zero_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (slot_free) begin
          out_valid_d = 1'b0;
        end
        if (in_valid) begin
          if (|encoder_in) begin
            pending_d = encoder_in;
            state_d   = BUSY;
          end else begin
            zero_d = 1'b1;
          end
        end
      end
      BUSY: begin
        if (slot_free) begin
          if (found) begin
            out_d       = pick;
            out_valid_d = 1'b1;
            last_d      = (remaining == '0);
            pending_d   = remaining;
            ptr_d       = (pick == LAST_IDX) ? '0 : pick + 1'b1;
            if (remaining == '0) begin
              state_d = IDLE;
            end
          end else begin
            // Unreachable in normal operation; recover instead of stalling.
            out_valid_d = 1'b0;
            state_d     = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      pending_q   <= '0;
      ptr_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      last_q      <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      ptr_q       <= ptr_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      last_q      <= last_d;
      zero_q      <= zero_d;
    end
  end

  assign in_ready     = (state_q == IDLE);
  assign encoder_out  = out_q;
  assign out_valid    = out_valid_q;
  assign encoder_last = last_q;
  assign encoder_zero = zero_q;
  assign dbg_busy     = (state_q == BUSY);
  assign dbg_ptr      = ptr_q;

endmodule

// File: tb/tb_netwalk_encoder.sv
// Bench for netwalk_encoder: directed scenarios with literal expectations plus a long
// randomized run checked every cycle against a vector-level reference model.
module tb_netwalk_encoder;

  localparam int OW = 4;
  localparam int IW = 16;

  logic          clk;
  logic          reset;
  logic [IW-1:0] encoder_in;
  logic          in_valid;
  logic          in_ready;
  logic [OW-1:0] encoder_out;
  logic          out_valid;
  logic          out_ready;
  logic          encoder_last;
  logic          encoder_zero;
  logic          dbg_busy;
  logic [OW-1:0] dbg_ptr;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  netwalk_encoder #(
    .ENCODER_OUT_WIDTH(OW),
    .ENCODER_IN_WIDTH (IW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .encoder_in  (encoder_in),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .encoder_out (encoder_out),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .encoder_last(encoder_last),
    .encoder_zero(encoder_zero),
    .dbg_busy    (dbg_busy),
    .dbg_ptr     (dbg_ptr)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, n_fail=%0d", n_fail);
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  // On accept the whole index sequence of the vector is expanded into exp_q; the
  // output slot then pops one entry per free slot. The block is busy while exp_q is non-empty.
  logic [OW-1:0] exp_q[$];
  int            m_ptr   = 0;
  logic [OW-1:0] m_out   = '0;
  bit            m_valid = 1'b0;
  bit            m_last  = 1'b0;
  bit            m_zero  = 1'b0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      exp_q.delete();
      m_ptr   = 0;
      m_out   = '0;
      m_valid = 1'b0;
      m_last  = 1'b0;
      m_zero  = 1'b0;
    end else begin
      bit busy;
      busy   = (exp_q.size() != 0);
      m_zero = 1'b0;
      if (!m_valid || out_ready) begin
        if (busy) begin
          m_out   = exp_q.pop_front();
          m_valid = 1'b1;
          m_last  = (exp_q.size() == 0);
        end else begin
          m_valid = 1'b0;
        end
      end
      if (!busy && in_valid) begin
        if (encoder_in == '0) begin
          m_zero = 1'b1;
        end else begin
          for (int i = 0; i < IW; i++) begin
            int j;
            j = (m_ptr + i) % IW;
            if (encoder_in[j]) exp_q.push_back(OW'(j));
          end
          m_ptr = (int'(exp_q[$]) + 1) % IW;
        end
      end
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_in_ready", 32'(in_ready), 32'(exp_q.size() == 0));
      check("model_out_valid", 32'(out_valid), 32'(m_valid));
      check("model_zero", 32'(encoder_zero), 32'(m_zero));
      if (m_valid) begin
        check("model_out", 32'(encoder_out), 32'(m_out));
        check("model_last", 32'(encoder_last), 32'(m_last));
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Presents v on a negedge once in_ready is seen, returns at the negedge after acceptance.
  task automatic accept_vec(input logic [IW-1:0] v);
    for (int k = 0; k < 200 && !in_ready; k++) @(negedge clk);
    if (!in_ready) check("accept_timeout", 32'(in_ready), 32'd1);
    in_valid   = 1'b1;
    encoder_in = v;
    @(negedge clk);
    in_valid   = 1'b0;
    encoder_in = '0;
  endtask

  task automatic pulse_reset();
    #2 reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic expect_out(input string name, input int idx, input bit last);
    check({name, "_valid"}, 32'(out_valid), 32'd1);
    check({name, "_out"}, 32'(encoder_out), 32'(idx));
    check({name, "_last"}, 32'(encoder_last), 32'(last));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int exp_b[3];
    bit lst_b[3];
    exp_b = '{15, 0, 4};
    lst_b = '{1'b0, 1'b0, 1'b1};

    reset      = 1'b0;
    in_valid   = 1'b0;
    encoder_in = '0;
    out_ready  = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out", 32'(encoder_out), 32'd0);
    check("rst_last", 32'(encoder_last), 32'd0);
    check("rst_zero", 32'(encoder_zero), 32'd0);
    check("rst_ptr", 32'(dbg_ptr), 32'd0);
    reset = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);

    // A: two indices, pointer advances past the last one
    out_ready = 1'b1;
    accept_vec(16'h0090);
    check("A_latency", 32'(out_valid), 32'd0);
    check("A_busy", 32'(in_ready), 32'd0);
    @(negedge clk);
    expect_out("A0", 4, 1'b0);
    @(negedge clk);
    expect_out("A1", 7, 1'b1);
    check("A_in_ready", 32'(in_ready), 32'd1);
    check("A_ptr", 32'(dbg_ptr), 32'd8);
    check("A_model_ptr", 32'(m_ptr), 32'd8);

    // B: search starts at 8 and wraps
    accept_vec(16'h8011);
    check("B_gap", 32'(out_valid), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      expect_out("B", exp_b[i], lst_b[i]);
    end
    check("B_model_ptr", 32'(m_ptr), 32'd5);

    // C: full vector from ptr 0
    pulse_reset();
    accept_vec(16'hFFFF);
    check("C_gap", 32'(out_valid), 32'd0);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      expect_out("C", i, i == 15);
    end
    check("C_ptr", 32'(dbg_ptr), 32'd0);

    // D: back-pressure holds the first index
    @(negedge clk);
    out_ready = 1'b0;
    accept_vec(16'h0006);
    @(negedge clk);
    expect_out("D_first", 1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      expect_out("D_hold", 1, 1'b0);
      check("D_hold_ptr", 32'(dbg_ptr), 32'd2);
    end
    out_ready = 1'b1;
    @(negedge clk);
    expect_out("D_second", 2, 1'b1);
    @(negedge clk);
    check("D_drained", 32'(out_valid), 32'd0);

    // E: all-zero vector
    accept_vec(16'h0000);
    check("E_zero", 32'(encoder_zero), 32'd1);
    check("E_valid", 32'(out_valid), 32'd0);
    check("E_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    check("E_zero_pulse", 32'(encoder_zero), 32'd0);

    // F: reset mid-vector discards the rest
    accept_vec(16'h00F0);
    @(negedge clk);
    expect_out("F_first", 4, 1'b0);
    #2 reset = 1'b0;
    #1;
    check("F_rst_valid", 32'(out_valid), 32'd0);
    check("F_rst_out", 32'(encoder_out), 32'd0);
    check("F_rst_last", 32'(encoder_last), 32'd0);
    check("F_rst_ready", 32'(in_ready), 32'd1);
    check("F_rst_busy", 32'(dbg_busy), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("F_rel_ready", 32'(in_ready), 32'd1);
    check("F_rel_valid", 32'(out_valid), 32'd0);
    accept_vec(16'h0001);
    @(negedge clk);
    expect_out("F_next", 0, 1'b1);

    // Randomized traffic with back-pressure, busy-time in_valid and occasional resets
    for (int cyc = 0; cyc < 3000; cyc++) begin
      int mode;
      @(negedge clk);
      out_ready = ($urandom_range(0, 3) != 0);
      in_valid  = ($urandom_range(0, 2) == 0);
      mode      = $urandom_range(0, 3);
      case (mode)
        0:       encoder_in = '0;
        1:       encoder_in = IW'(1) << $urandom_range(0, IW - 1);
        2:       encoder_in = IW'($urandom);
        default: encoder_in = IW'($urandom) & IW'($urandom) & IW'($urandom);
      endcase
      if ($urandom_range(0, 499) == 0) pulse_reset();
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (40) @(negedge clk);
    check("end_idle", 32'(in_ready), 32'd1);
    check("end_drained", 32'(out_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/netwalk_encoder.md
NETWALK_ENCODER -- requirements
Module: netwalk_encoder

Interface
REQ-001 The block SHALL have parameter ENCODER_OUT_WIDTH, default 4, giving the width of the binary index output.
REQ-002 The block SHALL have parameter ENCODER_IN_WIDTH, default 1<<ENCODER_OUT_WIDTH, giving the width of the request vector.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port encoder_in, input, ENCODER_IN_WIDTH bits: the request vector (any number of bits set).
REQ-006 The block SHALL have port in_valid, input, 1 bit: encoder_in is valid this cycle.
REQ-007 The block SHALL have port in_ready, output, 1 bit: the block accepts encoder_in this cycle.
REQ-008 The block SHALL have port encoder_out, output, ENCODER_OUT_WIDTH bits: the binary index of one set request bit.
REQ-009 The block SHALL have port out_valid, output, 1 bit: encoder_out is valid.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the downstream consumes encoder_out this cycle.
REQ-011 The block SHALL have port encoder_last, output, 1 bit: the current encoder_out is the final index of its vector.
REQ-012 The block SHALL have port encoder_zero, output, 1 bit: one-cycle pulse when an all-zero vector is accepted.

Function
REQ-013 The block SHALL implement FSM states IDLE and BUSY, with an internal pending register (ENCODER_IN_WIDTH bits) and a round-robin pointer ptr (ENCODER_OUT_WIDTH bits).
REQ-014 in_ready SHALL be 1 in IDLE and 0 in BUSY, driven from the state register only.
REQ-015 Accept condition: in IDLE with in_valid=1, the vector SHALL be accepted at the rising edge.
REQ-016 On accept of a nonzero vector, the block SHALL load pending=encoder_in and enter BUSY.
REQ-017 On accept of an all-zero vector, the block SHALL stay in IDLE, set encoder_zero=1 for exactly the next cycle, and not assert out_valid for that vector.
REQ-018 Output slot: the slot is free when out_valid=0 or out_ready=1.
REQ-019 When the slot is free in BUSY, the block SHALL choose the first set pending bit at index >= ptr, searching upward and wrapping modulo ENCODER_IN_WIDTH.
REQ-020 At that same edge, the block SHALL register encoder_out=chosen index and out_valid=1.
REQ-021 At that same edge, the block SHALL clear the chosen bit in pending and set ptr=(index+1) mod ENCODER_IN_WIDTH, wrapping from 15 to 0 at the default width.
REQ-022 At that same edge, encoder_last SHALL be 1 if the remaining pending bits are zero after clearing, else 0.
REQ-023 When encoder_last is emitted, the FSM SHALL return to IDLE at the same edge.
REQ-024 Latency: the first index SHALL appear (out_valid=1) at the edge after accept.
REQ-025 Throughput: with out_ready held at 1, the block SHALL emit one index per cycle, so a vector with k set bits takes k cycles.
REQ-026 Back-pressure: while out_valid=1 and out_ready=0, encoder_out and encoder_last SHALL remain stable, and pending and ptr SHALL not change.
REQ-027 When the slot is free and no new index is available, out_valid SHALL deassert at the edge after consumption.
REQ-028 A new vector SHALL be accepted in IDLE even while the last index of the previous vector is still held; the held output remains unchanged until consumed.
REQ-029 ptr SHALL persist across vectors and SHALL not be reloaded on accept.
REQ-030 in_valid in BUSY SHALL be ignored; the upstream must hold the vector until in_ready=1.

Reset
REQ-031 While reset=0, the block SHALL asynchronously force state=IDLE, pending=0, ptr=0, encoder_out=0, out_valid=0, encoder_last=0, encoder_zero=0, in_ready=1.
REQ-032 Reset mid-vector SHALL discard all pending bits, and no further outputs of that vector SHALL appear after release.

Verification
REQ-033 Scenario A: after reset, accept 16'h0090 with out_ready=1 -> encoder_out 4 (last=0), then 7 (last=1) on consecutive cycles; ptr=8; in_ready=1 the cycle after 7 is emitted.
REQ-034 Scenario B: following A, accept 16'h8011 -> outputs 15, 0, 4 with last=1 on 4, confirming pointer wrap.
REQ-035 Scenario C: accept 16'hFFFF with out_ready=1 from ptr=0 -> 0..15 on 16 consecutive cycles, last=1 only on 15.
REQ-036 Scenario D: accept 16'h0006, hold out_ready=0 for 5 cycles -> encoder_out stays 1 with out_valid=1; on release, outputs 1 then 2 (last=1).
REQ-037 Scenario E: accept 16'h0000 -> encoder_zero=1 for one cycle, out_valid stays 0, in_ready stays 1.
REQ-038 Scenario F: accept 16'h00F0, assert reset=0 after the first output -> all outputs 0 immediately; after release, in_ready=1, out_valid=0, and next vector 16'h0001 yields index 0.
